// File: rtl/bp_burst_latency_buffer.sv
// In-order delay queue for ready/valid burst streams: each beat becomes eligible a fixed
// (optionally LFSR-jittered) number of cycles after it is accepted, and leaves strictly FIFO.
module bp_burst_latency_buffer #(
  parameter int          width_p       = 64,
  parameter int          els_p         = 8,
  parameter int          latency_p     = 100,
  parameter int          jitter_mask_p = 0,
  parameter logic [15:0] lfsr_seed_p   = 16'hACE1
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [width_p-1:0]           data_i,
  input  logic                         last_i,
  input  logic                         v_i,
  output logic                         ready_and_o,
  output logic [width_p-1:0]           data_o,
  output logic                         last_o,
  output logic                         v_o,
  input  logic                         ready_and_i,
  output logic [$clog2(els_p+1)-1:0]   count_o
);

  // Counter is one bit wider than the largest delay, so an exact-match expiry test is wrap-safe.
  localparam int ctr_w = $clog2(latency_p + jitter_mask_p + 1) + 1;
  localparam int ptr_w = $clog2(els_p);
  localparam int cnt_w = $clog2(els_p + 1);

  typedef enum logic {ST_START, ST_BURST} burst_state_e;

  burst_state_e state_reg, state_next;

  logic [width_p-1:0] data_mem  [els_p];
  logic               last_mem  [els_p];
  logic [ctr_w-1:0]   stamp_mem [els_p];

  logic [els_p-1:0] valid_reg, valid_next;
  logic [els_p-1:0] expired_reg, expired_next;
  logic [els_p-1:0] hit_wr, hit_rd, stamp_hit;

  logic [ptr_w-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ptr_w-1:0] rd_ptr_reg, rd_ptr_next;
  logic [cnt_w-1:0] count_reg, count_next;
  logic [ctr_w-1:0] ctr_reg;
  logic [15:0]      lfsr_reg, lfsr_next;
  logic [ctr_w-1:0] delay_reg, delay_next;

  logic             accept, deq, lfsr_adv;
  logic             lfsr_fb;
  logic [ctr_w-1:0] delay_now, delay_sel, stamp_new;

  assign accept = v_i & ready_and_o;
  assign deq    = v_o & ready_and_i;

  assign ready_and_o = reset_n_i & (count_reg != cnt_w'(els_p));
  assign count_o     = count_reg;

  assign v_o    = reset_n_i & valid_reg[rd_ptr_reg]
                & (expired_reg[rd_ptr_reg] | stamp_hit[rd_ptr_reg]);
  assign data_o = data_mem[rd_ptr_reg];
  assign last_o = last_mem[rd_ptr_reg];

  // Delay is drawn once at the first beat of a burst and reused for the rest of that burst.
  assign delay_now = ctr_w'(latency_p) + ctr_w'(lfsr_reg & 16'(jitter_mask_p));
  assign delay_sel = (state_reg == ST_BURST) ? delay_reg : delay_now;
  assign stamp_new = ctr_reg + delay_sel;

  assign lfsr_fb = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];

  always_comb begin
    state_next = state_reg;
    lfsr_adv   = 1'b0;
    if (accept) begin
      if (state_reg == ST_START) begin
        lfsr_adv = 1'b1;
      end
      state_next = last_i ? ST_START : ST_BURST;
    end
  end

  always_comb begin
    lfsr_next  = lfsr_reg;
    delay_next = delay_reg;
    if (lfsr_adv) begin
      lfsr_next  = {lfsr_reg[14:0], lfsr_fb};
      delay_next = delay_now;
    end
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (accept) begin
      wr_ptr_next = (wr_ptr_reg == ptr_w'(els_p - 1)) ? '0 : wr_ptr_reg + ptr_w'(1);
    end
    if (deq) begin
      rd_ptr_next = (rd_ptr_reg == ptr_w'(els_p - 1)) ? '0 : rd_ptr_reg + ptr_w'(1);
    end
    if (accept && !deq) begin
      count_next = count_reg + cnt_w'(1);
    end else if (deq && !accept) begin
      count_next = count_reg - cnt_w'(1);
    end
  end

  // Every occupied entry watches the counter, so an entry stalled behind the head still expires.
  genvar gi;
  generate
    for (gi = 0; gi < els_p; gi++) begin : g_entry
      assign hit_wr[gi]       = accept & (wr_ptr_reg == ptr_w'(gi));
      assign hit_rd[gi]       = deq & (rd_ptr_reg == ptr_w'(gi));
      assign stamp_hit[gi]    = valid_reg[gi] & (ctr_reg == stamp_mem[gi]);
      assign valid_next[gi]   = hit_wr[gi] | (valid_reg[gi] & ~hit_rd[gi]);
      assign expired_next[gi] = ~hit_wr[gi] & ~hit_rd[gi] & (expired_reg[gi] | stamp_hit[gi]);
    end
  endgenerate

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg   <= ST_START;
      ctr_reg     <= '0;
      lfsr_reg    <= lfsr_seed_p;
      delay_reg   <= '0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      valid_reg   <= '0;
      expired_reg <= '0;
    end else begin
      state_reg   <= state_next;
      ctr_reg     <= ctr_reg + ctr_w'(1);
      lfsr_reg    <= lfsr_next;
      delay_reg   <= delay_next;
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      count_reg   <= count_next;
      valid_reg   <= valid_next;
      expired_reg <= expired_next;
    end
  end

  // Payload storage carries no reset; the valid bits alone say which entries are meaningful.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      data_mem[wr_ptr_reg]  <= data_i;
      last_mem[wr_ptr_reg]  <= last_i;
      stamp_mem[wr_ptr_reg] <= stamp_new;
    end
  end

`ifndef SYNTHESIS
  param_check: assert property (@(posedge clk_i) (latency_p >= 1) && (lfsr_seed_p != 16'h0));

  hold_check: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (v_i && !ready_and_o) |=> (v_i && $stable(data_i) && $stable(last_i)));
`endif

endmodule

// File: tb/tb_bp_burst_latency_buffer.sv
// Scoreboard bench: two instances (fixed latency / jittered latency), exact per-cycle v_o check
// against each queued beat's due cycle, plus directed occupancy and reset checks.
module tb_bp_burst_latency_buffer;

  localparam int L0 = 5;
  localparam int J0 = 0;
  localparam int L1 = 3;
  localparam int J1 = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [1:0]       v_in, last_in, rdy_in, v_out, last_out, rdy_out;
  logic [1:0][15:0] d_in, d_out;
  logic [2:0]       cnt0;
  logic [3:0]       cnt1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] data;
    logic        last;
    int          due;
  } sb_t;

  sb_t         sb [2][$];
  logic [15:0] m_lfsr [2];
  logic        m_inb  [2];
  int          m_dly  [2];
  int          lat    [2];
  int          jm     [2];

  int checks = 0;
  int fails  = 0;

  bp_burst_latency_buffer #(
    .width_p(16), .els_p(4), .latency_p(L0), .jitter_mask_p(J0), .lfsr_seed_p(16'hACE1)
  ) u_dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .data_i(d_in[0]), .last_i(last_in[0]), .v_i(v_in[0]), .ready_and_o(rdy_out[0]),
    .data_o(d_out[0]), .last_o(last_out[0]), .v_o(v_out[0]), .ready_and_i(rdy_in[0]),
    .count_o(cnt0)
  );

  bp_burst_latency_buffer #(
    .width_p(16), .els_p(8), .latency_p(L1), .jitter_mask_p(J1), .lfsr_seed_p(16'hACE1)
  ) u_jit (
    .clk_i(clk), .reset_n_i(rst_n),
    .data_i(d_in[1]), .last_i(last_in[1]), .v_i(v_in[1]), .ready_and_o(rdy_out[1]),
    .data_o(d_out[1]), .last_o(last_out[1]), .v_o(v_out[1]), .ready_and_i(rdy_in[1]),
    .count_o(cnt1)
  );

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d cyc=%0d actual=%0h expected=%0h", name, k, cyc, act, exp);
    end
  endtask

  task automatic reset_models();
    for (int k = 0; k < 2; k++) begin
      sb[k].delete();
      m_lfsr[k] = 16'hACE1;
      m_inb[k]  = 1'b0;
      m_dly[k]  = 0;
    end
  endtask

  // Expected delay for an accepted beat: drawn at burst start from the reference LFSR.
  task automatic model_delay(input int k, input logic l, output int d);
    logic fb;
    if (!m_inb[k]) begin
      m_dly[k]  = lat[k] + int'(m_lfsr[k] & 16'(jm[k]));
      fb        = m_lfsr[k][15] ^ m_lfsr[k][13] ^ m_lfsr[k][12] ^ m_lfsr[k][10];
      m_lfsr[k] = {m_lfsr[k][14:0], fb};
    end
    m_inb[k] = !l;
    d = m_dly[k];
  endtask

  // Called at posedge+1; returns at posedge+1 after the accept with v_i still high.
  task automatic push_beat(input int k, input logic [15:0] d, input logic l);
    bit  done;
    int  dl;
    sb_t e;
    done     = 1'b0;
    v_in[k]  = 1'b1;
    d_in[k]  = d;
    last_in[k] = l;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (rdy_out[k]) begin
        model_delay(k, l, dl);
        e.data = d;
        e.last = l;
        e.due  = cyc + dl;
        sb[k].push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      fails++;
      $display("FAIL push_timeout dut%0d cyc=%0d actual=no_accept expected=accept", k, cyc);
      v_in[k] = 1'b0;
    end
  endtask

  task automatic idle(input int k, input int n);
    v_in[k] = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_port(input int k);
    sb_t e;
    if (!rst_n) begin
      chk("v_in_reset", k, 32'(v_out[k]), 32'd0);
      chk("ready_in_reset", k, 32'(rdy_out[k]), 32'd0);
    end else if (sb[k].size() == 0) begin
      chk("v_when_empty", k, 32'(v_out[k]), 32'd0);
    end else begin
      e = sb[k][0];
      chk("v_eligible", k, 32'(v_out[k]), 32'(cyc >= e.due));
      if (v_out[k]) begin
        chk("data", k, 32'(d_out[k]), 32'(e.data));
        chk("last", k, 32'(last_out[k]), 32'(e.last));
        if (rdy_in[k]) void'(sb[k].pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    check_port(0);
    check_port(1);
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    int gap;
    logic [15:0] dval;
    lat[0] = L0; lat[1] = L1;
    jm[0]  = J0; jm[1]  = J1;
    rst_n   = 1'b0;
    v_in    = '0;
    last_in = '0;
    d_in    = '0;
    rdy_in  = 2'b11;
    reset_models();
    repeat (3) @(posedge clk);
    #1;
    chk("count_reset", 0, 32'(cnt0), 32'd0);
    chk("count_reset", 1, 32'(cnt1), 32'd0);
    rst_n = 1'b1;

    // T1: single beat accepted in cycle 10 is due in cycle 15
    while (cyc < 10) begin
      @(posedge clk);
      #1;
    end
    push_beat(0, 16'hA001, 1'b1);
    idle(0, 8);

    // T2: fill to depth with the consumer stalled, then free one slot
    rdy_in[0] = 1'b0;
    for (int i = 0; i < 4; i++) push_beat(0, 16'hB000 + 16'(i), 1'b1);
    idle(0, 8);
    @(negedge clk);
    chk("count_full", 0, 32'(cnt0), 32'd4);
    chk("ready_full", 0, 32'(rdy_out[0]), 32'd0);
    @(posedge clk);
    #1;
    rdy_in[0] = 1'b1;
    @(posedge clk);
    #1;
    rdy_in[0] = 1'b0;
    @(negedge clk);
    chk("ready_after_pop", 0, 32'(rdy_out[0]), 32'd1);
    chk("count_after_pop", 0, 32'(cnt0), 32'd3);
    @(posedge clk);
    #1;
    rdy_in[0] = 1'b1;
    idle(0, 8);

    // T3: four-beat burst, back to back in and out
    for (int i = 0; i < 4; i++) push_beat(0, 16'hC000 + 16'(i), i == 3);
    idle(0, 12);

    // T4: jittered instance, 50 bursts of 1..4 beats with random gaps
    dval = 16'h4000;
    for (int b = 0; b < 50; b++) begin
      len = 1 + int'($urandom_range(3, 0));
      for (int j = 0; j < len; j++) begin
        push_beat(1, dval, j == len - 1);
        dval = dval + 16'd1;
      end
      gap = int'($urandom_range(3, 0));
      idle(1, gap);
    end
    idle(1, 30);

    // T5: long stall across many counter wraps, then drain back to back
    rdy_in[0] = 1'b0;
    for (int i = 0; i < 3; i++) push_beat(0, 16'hE000 + 16'(i), 1'b1);
    idle(0, 300);
    rdy_in[0] = 1'b1;
    idle(0, 10);

    // T6: reset in the middle of a burst with three entries queued
    rdy_in[0] = 1'b0;
    for (int i = 0; i < 3; i++) push_beat(0, 16'hF000 + 16'(i), 1'b0);
    idle(0, 2);
    #3;
    rst_n = 1'b0;
    reset_models();
    #1;
    chk("v_async_reset", 0, 32'(v_out[0]), 32'd0);
    chk("count_async_reset", 0, 32'(cnt0), 32'd0);
    chk("ready_async_reset", 0, 32'(rdy_out[0]), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rdy_in[0] = 1'b1;
    push_beat(0, 16'hF0F0, 1'b1);
    idle(0, 10);

    chk("drained", 0, 32'(sb[0].size()), 32'd0);
    chk("drained", 1, 32'(sb[1].size()), 32'd0);
    chk("count_end", 0, 32'(cnt0), 32'd0);
    chk("count_end", 1, 32'(cnt1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
